uart_rx_sampler: RTL
====================

# uart_rx_sampler

Front-end timing stage of the UART receiver: synchronises the raw serial line, runs the oversampling edge and bit counters, and takes a 3-sample majority vote around each bit centre. Sits between the RX_IN pin and the receive FSM/deserializer, and is the sole source of `edge_count`, `bit_count` and `sampled_bit`. The FSM controls it only through `cnt_en`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: depth of the RX_IN synchroniser flop chain. Legal values are 2 and 3.

Ports:
- `clk`  in  1  receiver oversampling clock.
- `rst`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  raw serial line. Idle level is 1.
- `Prescale`  in  6  oversampling ratio. Legal values are 8, 16 and 32; any other value is treated as 8. Must be held stable while `cnt_en`=1.
- `cnt_en`  in  1  from the FSM. 1 means count and sample; 0 means hold the counters cleared.
- `rx_sync`  out  1  synchronised RX_IN, for start-bit detection by the FSM.
- `edge_count`  out  5  oversample index within the current bit, 0..Prescale-1.
- `bit_count`  out  4  index of the current bit within the frame. 0 is the start bit.
- `sampled_bit`  out  1  majority-voted value of the current bit.
- `sample_valid`  out  1  one-cycle pulse marking that `sampled_bit` is fresh.
- `noise_err`  out  1  samples disagreed (see Configuration).

## Operation
- Synchroniser:
  - `SYNC_STAGES` flops in series; every flop resets to 1.
  - `rx_sync` is the last stage.
  - All sampling uses `rx_sync`, never RX_IN.
- Define H = Prescale>>1, computed at 6 bits then truncated to 5. With Prescale=8, H=4.
- Edge counter:
  - `cnt_en`=0: `edge_count` <= 0 and `bit_count` <= 0 on every clock.
  - `cnt_en`=1 and `edge_count` != Prescale-1: `edge_count` increments.
  - `cnt_en`=1 and `edge_count` == Prescale-1: `edge_count` <= 0 and `bit_count` increments.
  - `bit_count` saturates at 15; it never wraps.
- Sampling, only while `cnt_en`=1:
  - Register s0 captures `rx_sync` on the edge where `edge_count` == H-1.
  - Register s1 captures `rx_sync` on the edge where `edge_count` == H.
  - On the edge where `edge_count` == H+1, `sampled_bit` <= majority(s0, s1, `rx_sync`).
- `sample_valid` is a register that is 1 exactly during the cycle in which `edge_count` == H+2.
  - This is the cycle in which downstream stages capture `sampled_bit`.
- `sampled_bit` holds its value between updates. It is not cleared when `cnt_en` falls.
- When `cnt_en` falls mid-bit:
  - Counters clear on the next edge.
  - No further `sample_valid` is issued.
  - s0 and s1 keep stale values; the next vote overwrites them before they are used.

## Timing
- Reset (rst=0), all outputs asynchronously forced:
  - `rx_sync`=1, `sampled_bit`=1.
  - `edge_count`=0, `bit_count`=0.
  - `sample_valid`=0, `noise_err`=0.
- Synchroniser latency: a change on RX_IN appears on `rx_sync` `SYNC_STAGES` clocks later.
- From the rising edge where `cnt_en` is first sampled 1: `edge_count`=1 on that edge, H+2 after H+2 edges.
  - Hence the first `sample_valid` is high in the (H+2)-th cycle after `cnt_en` rises.
- Per bit:
  - Exactly one `sample_valid` per Prescale clocks.
  - Successive `sample_valid` pulses are Prescale cycles apart.
- Simultaneous `edge_count` wrap and `cnt_en`=0: the clear wins; `bit_count` stays 0.
- Reset asserted mid-frame takes effect immediately. After release, the block is idle until `cnt_en` is sampled 1.

## Configuration
- Macro `UART_RX_NOISE_FLAG_EN`.
- Defined:
  - `noise_err` is registered with `sample_valid`.
  - It is 1 in the `sample_valid` cycle when s0, s1 and the third sample were not all equal.
  - Otherwise it is 0.
- Undefined:
  - `noise_err` is tied to 0.
  - No comparison logic is synthesised.
  - All other behaviour is identical.

## Test plan
- Reset, then hold RX_IN=1 with rst released and `cnt_en`=0 for 20 clocks:
  - `rx_sync`=1, `edge_count`=0, `bit_count`=0 throughout.
  - `sample_valid` never asserts.
- Prescale=8, `cnt_en`=1, frame 0,0xA5 (LSB first),1:
  - `sample_valid` asserts when `edge_count`=6, every 8 clocks.
  - `sampled_bit` reads 0,1,0,1,0,0,1,0,1,1 against `bit_count` 0..9.
- Prescale=16 and Prescale=32, same frame:
  - Pulse spacing is 16 and 32 clocks respectively.
  - `sample_valid` coincides with `edge_count`=10 and 18 respectively.
  - Data is correct.
- Noise injection, Prescale=8, bit nominally 1, glitch to 0 only during the H-1 sample:
  - `sampled_bit`=1.
  - With `UART_RX_NOISE_FLAG_EN` defined: `noise_err`=1 for one cycle, coincident with `sample_valid`.
  - Without it: `noise_err` stays 0.
- Drop `cnt_en` at `edge_count`=3 of bit 4:
  - Next cycle `edge_count`=0 and `bit_count`=0.
  - No `sample_valid`.
  - `sampled_bit` retains the bit-3 value.
- Assert rst at `edge_count`=5 mid-frame:
  - All outputs take their reset values immediately, without waiting for `clk`.
  - After release with `cnt_en`=1, the first `sample_valid` arrives 6 cycles later (Prescale=8).

Source files
------------

// File: rtl/uart_rx_sampler_if.sv
// Timing bus between uart_rx_sampler (master) and the receive FSM/deserializer (slave).
interface uart_rx_sampler_if;
    localparam int unsigned EDGE_W = 5;
    localparam int unsigned BIT_W  = 4;

    logic              cnt_en;
    logic              rx_sync;
    logic [EDGE_W-1:0] edge_count;
    logic [BIT_W-1:0]  bit_count;
    logic              sampled_bit;
    logic              sample_valid;
    logic              noise_err;

    modport master (
        input  cnt_en,
        output rx_sync,
        output edge_count,
        output bit_count,
        output sampled_bit,
        output sample_valid,
        output noise_err
    );

    modport slave (
        output cnt_en,
        input  rx_sync,
        input  edge_count,
        input  bit_count,
        input  sampled_bit,
        input  sample_valid,
        input  noise_err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART RX front end: RX_IN synchroniser, oversample edge/bit counters, 3-sample majority vote.
// Optional macro UART_RX_NOISE_FLAG_EN enables the registered noise_err flag.
module uart_rx_sampler #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX_IN,
    input  logic [5:0]        Prescale,
    uart_rx_sampler_if.master bus
);
    localparam int unsigned EDGE_W = 5;
    localparam int unsigned BIT_W  = 4;
    localparam logic [BIT_W-1:0] BIT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_sync;
    logic [EDGE_W-1:0]      edge_q;
    logic [BIT_W-1:0]       bit_q;
    logic                   s0_q;
    logic                   s1_q;
    logic                   sampled_q;
    logic                   valid_q;

    logic [EDGE_W-1:0]      last_c;
    logic [EDGE_W-1:0]      half_c;
    logic [EDGE_W-1:0]      half_m1_c;
    logic [EDGE_W-1:0]      half_p1_c;
    logic                   vote_c;
    logic                   take_c;

    // Synchroniser chain; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];

    // Unsupported ratios fall back to 8x oversampling
    always_comb begin
        last_c = 5'd7;
        half_c = 5'd4;
        case (Prescale)
            6'd16: begin
                last_c = 5'd15;
                half_c = 5'd8;
            end
            6'd32: begin
                last_c = 5'd31;
                half_c = 5'd16;
            end
            default: begin
                last_c = 5'd7;
                half_c = 5'd4;
            end
        endcase
        half_m1_c = half_c - 5'd1;
        half_p1_c = half_c + 5'd1;
    end

    // Edge/bit counters; dropping cnt_en clears them even on a wrap edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (!bus.cnt_en) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (edge_q == last_c) begin
            edge_q <= '0;
            if (bit_q != BIT_MAX) begin
                bit_q <= bit_q + 4'd1;
            end
        end else begin
            edge_q <= edge_q + 5'd1;
        end
    end

    assign take_c = bus.cnt_en && (edge_q == half_p1_c);
    assign vote_c = (s0_q & s1_q) | (s0_q & rx_sync) | (s1_q & rx_sync);

    // Samples either side of the bit centre, then the vote on the third
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            sampled_q <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            if (bus.cnt_en && (edge_q == half_m1_c)) begin
                s0_q <= rx_sync;
            end
            if (bus.cnt_en && (edge_q == half_c)) begin
                s1_q <= rx_sync;
            end
            if (take_c) begin
                sampled_q <= vote_c;
            end
            valid_q <= take_c;
        end
    end

`ifdef UART_RX_NOISE_FLAG_EN
    logic noise_q;

    // Flags any disagreement among the three votes, aligned with sample_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            noise_q <= 1'b0;
        end else begin
            noise_q <= take_c && !((s0_q == s1_q) && (s1_q == rx_sync));
        end
    end

    assign bus.noise_err = noise_q;
`else
    assign bus.noise_err = 1'b0;
`endif

    assign bus.rx_sync      = rx_sync;
    assign bus.edge_count   = edge_q;
    assign bus.bit_count    = bit_q;
    assign bus.sampled_bit  = sampled_q;
    assign bus.sample_valid = valid_q;
endmodule
